// File: rtl/rle_plane_reader.sv
// Planar pixel fetcher: walks NCH colour planes stored back-to-back in a pixel RAM
// and assembles one NCH-channel pixel per plane offset behind a valid/ready handshake.
module rle_plane_reader #(
    parameter int NCH        = 3,
    parameter int DW         = 8,
    parameter int AW         = 16,
    parameter int PLANE      = 16384,
    parameter int RD_LAT     = 0,
    parameter int CONTINUOUS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [AW-1:0]     a,
    input  logic [DW-1:0]     spo,
    output logic [NCH*DW-1:0] pix,
    output logic              valid,
    input  logic              ready,
    output logic              last,
    output logic              busy,
    output logic              done
);
    localparam int OW = (PLANE > 1) ? $clog2(PLANE) : 1;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, CAP, OUT} state_t;

    state_t                 state;
    logic [OW-1:0]          offset;
    logic [CW-1:0]          ch;
    logic [LW-1:0]          lat_cnt;
    logic [NCH-1:0][DW-1:0] pix_q;

    assign pix = pix_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            offset  <= '0;
            ch      <= '0;
            lat_cnt <= '0;
            a       <= '0;
            pix_q   <= '0;
            valid   <= 1'b0;
            last    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start landing on the done pulse belongs to the frame just finished.
                    if (start && !done) begin
                        state  <= ADDR;
                        offset <= '0;
                        ch     <= '0;
                        busy   <= 1'b1;
                    end
                end
                ADDR: begin
                    a       <= AW'(ch) * AW'(PLANE) + AW'(offset);
                    lat_cnt <= '0;
                    state   <= (RD_LAT > 0) ? WAIT : CAP;
                end
                WAIT: begin
                    if (lat_cnt == LW'(RD_LAT - 1)) begin
                        state <= CAP;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                CAP: begin
                    pix_q[ch] <= spo;
                    if (ch != CW'(NCH - 1)) begin
                        ch    <= ch + CW'(1);
                        state <= ADDR;
                    end else begin
                        ch    <= '0;
                        valid <= 1'b1;
                        last  <= (offset == OW'(PLANE - 1));
                        state <= OUT;
                    end
                end
                OUT: begin
                    // valid is always high here, so ready alone marks the transfer.
                    if (ready) begin
                        valid <= 1'b0;
                        last  <= 1'b0;
                        if (!last) begin
                            offset <= offset + OW'(1);
                            state  <= ADDR;
                        end else begin
                            done   <= 1'b1;
                            offset <= '0;
                            busy   <= (CONTINUOUS != 0);
                            state  <= (CONTINUOUS != 0) ? ADDR : IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rle_plane_reader.sv
// Bench for rle_plane_reader: three configurations (base, registered-read 4-channel,
// continuous) with random RAM contents and backpressure, checked against a frame model.
module tb_rle_plane_reader;
    localparam int PL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       start_v;
    logic [2:0]       rdy_v;
    logic [2:0]       rst_v;
    logic [2:0]       valid_w, last_w, busy_w, done_w;
    logic [2:0][3:0]  a_v;
    logic [23:0]      pix0, pix2;
    logic [31:0]      pix1;
    logic [7:0]       spo0, spo1, spo2;
    logic [31:0]      pix_v [3];
    logic [7:0]       mem [3][16];

    int n_chk = 0;
    int n_pass = 0;

    assign pix_v[0] = {8'h00, pix0};
    assign pix_v[1] = pix1;
    assign pix_v[2] = {8'h00, pix2};
    assign spo0 = mem[0][a_v[0]];
    assign spo2 = mem[2][a_v[2]];
    always @(posedge clk) spo1 <= mem[1][a_v[1]];

    rle_plane_reader #(.NCH(3), .DW(8), .AW(4), .PLANE(PL), .RD_LAT(0), .CONTINUOUS(0)) u0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .a(a_v[0]), .spo(spo0), .pix(pix0),
        .valid(valid_w[0]), .ready(rdy_v[0]), .last(last_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    rle_plane_reader #(.NCH(4), .DW(8), .AW(4), .PLANE(PL), .RD_LAT(1), .CONTINUOUS(0)) u1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .a(a_v[1]), .spo(spo1), .pix(pix1),
        .valid(valid_w[1]), .ready(rdy_v[1]), .last(last_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    rle_plane_reader #(.NCH(3), .DW(8), .AW(4), .PLANE(PL), .RD_LAT(0), .CONTINUOUS(1)) u2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .a(a_v[2]), .spo(spo2), .pix(pix2),
        .valid(valid_w[2]), .ready(rdy_v[2]), .last(last_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    function automatic int nch_of(input int i);
        return (i == 1) ? 4 : 3;
    endfunction
    function automatic int rdl_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction
    function automatic int cont_of(input int i);
        return (i == 2) ? 1 : 0;
    endfunction

    // Reference pixel: channel c of offset k lives at c*PLANE + k.
    function automatic logic [31:0] exp_pix(input int i, input int k);
        logic [31:0] r;
        r = '0;
        for (int c = 0; c < nch_of(i); c++) r[c*8 +: 8] = mem[i][c*PL + k];
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic fill_rand(input int i);
        for (int j = 0; j < 16; j++) mem[i][j] = 8'($urandom);
    endtask

    task automatic check_zero(input int i);
        check_val("rst_a", 32'(a_v[i]), 0);
        check_val("rst_pix", pix_v[i], 0);
        check_val("rst_valid", 32'(valid_w[i]), 0);
        check_val("rst_last", 32'(last_w[i]), 0);
        check_val("rst_busy", 32'(busy_w[i]), 0);
        check_val("rst_done", 32'(done_w[i]), 0);
    endtask

    task automatic quiet_after_reset(input int i);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check_val("post_rst_done", 32'(done_w[i]), 0);
            check_val("post_rst_busy", 32'(busy_w[i]), 0);
        end
    endtask

    // One frame of PL pixels; with do_start=0 the frame is assumed to begin at the
    // previous transfer edge (continuous mode). Called and returns at a negedge.
    task automatic run_frame(input int i, input bit do_start, input int stall_k,
                             input int stall_n, input bit rnd);
        int lat, per, cnt, cyc, stall_tot, s;
        logic [31:0] ep;
        lat = nch_of(i) * (2 + rdl_of(i));
        per = 2 + rdl_of(i);
        cyc = 0;
        stall_tot = 0;
        if (do_start) begin
            @(negedge clk);
            start_v[i] = 1'b1;
            @(negedge clk);
            start_v[i] = 1'b0;
            check_val("busy_on", 32'(busy_w[i]), 1);
        end
        for (int k = 0; k < PL; k++) begin
            cnt = 0;
            while (!valid_w[i] && cnt <= lat + 4) begin
                @(negedge clk);
                cnt++;
                cyc++;
                if (cnt == 1) check_val("done_clr", 32'(done_w[i]), 0);
                if (cnt <= lat && (cnt - 1) % per == 0)
                    check_val("addr", 32'(a_v[i]), 32'((cnt - 1) / per * PL + k));
            end
            check_val("latency", 32'(cnt), 32'(lat));
            ep = exp_pix(i, k);
            check_val("pix", pix_v[i], ep);
            check_val("last", 32'(last_w[i]), 32'(k == PL - 1));
            s = (k == stall_k) ? stall_n : (rnd ? int'($urandom_range(0, 2)) : 0);
            stall_tot += s;
            if (s > 0) begin
                rdy_v[i] = 1'b0;
                for (int j = 0; j < s; j++) begin
                    @(negedge clk);
                    cyc++;
                    check_val("hold_valid", 32'(valid_w[i]), 1);
                    check_val("hold_pix", pix_v[i], ep);
                    check_val("hold_last", 32'(last_w[i]), 32'(k == PL - 1));
                    check_val("hold_a", 32'(a_v[i]), 32'((nch_of(i) - 1) * PL + k));
                end
                rdy_v[i] = 1'b1;
            end
            @(negedge clk);
            cyc++;
            check_val("valid_drop", 32'(valid_w[i]), 0);
            check_val("done", 32'(done_w[i]), 32'(k == PL - 1));
        end
        check_val("frame_len", 32'(cyc), 32'(PL * (lat + 1) + stall_tot));
        check_val("busy_end", 32'(busy_w[i]), 32'(cont_of(i)));
    endtask

    initial begin
        start_v = '0;
        rdy_v   = '1;
        rst_v   = '1;
        for (int j = 0; j < 16; j++) mem[0][j] = 8'(j * 16 + 1);
        fill_rand(1);
        fill_rand(2);
        repeat (2) @(negedge clk);
        check_zero(0);
        check_zero(1);
        rst_v = '0;
        @(negedge clk);

        // Base frame with the ramp pattern, then a start on the done cycle.
        run_frame(0, 1'b1, -1, 0, 1'b0);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_val("start_on_done_busy", 32'(busy_w[0]), 0);
            check_val("start_on_done_valid", 32'(valid_w[0]), 0);
        end

        fill_rand(0);
        run_frame(0, 1'b1, 1, 5, 1'b0);
        fill_rand(0);
        run_frame(0, 1'b1, -1, 0, 1'b1);

        // Asynchronous reset while a pixel waits in OUT.
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (6) @(negedge clk);
        check_val("pre_rst_valid", 32'(valid_w[0]), 1);
        rdy_v[0] = 1'b0;
        #2 rst_v[0] = 1'b1;
        #1 check_zero(0);
        @(negedge clk);
        rst_v[0] = 1'b0;
        rdy_v[0] = 1'b1;
        quiet_after_reset(0);
        fill_rand(0);
        run_frame(0, 1'b1, -1, 0, 1'b1);

        // Registered-read, four-channel instance.
        run_frame(1, 1'b1, -1, 0, 1'b0);
        fill_rand(1);
        run_frame(1, 1'b1, 2, 3, 1'b1);

        // Asynchronous reset while in WAIT.
        @(negedge clk);
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        @(negedge clk);
        check_val("pre_rst_busy", 32'(busy_w[1]), 1);
        #2 rst_v[1] = 1'b1;
        #1 check_zero(1);
        @(negedge clk);
        rst_v[1] = 1'b0;
        quiet_after_reset(1);
        fill_rand(1);
        run_frame(1, 1'b1, -1, 0, 1'b1);

        // Continuous instance: back-to-back frames, a stray start mid-frame.
        run_frame(2, 1'b1, -1, 0, 1'b0);
        fill_rand(2);
        fork
            run_frame(2, 1'b0, -1, 0, 1'b1);
            begin
                repeat (10) @(negedge clk);
                start_v[2] = 1'b1;
                @(negedge clk);
                start_v[2] = 1'b0;
            end
        join
        fill_rand(2);
        run_frame(2, 1'b0, 0, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rle_plane_reader.md
# rle_plane_reader

Parametrised planar-pixel fetcher that walks NCH colour planes stored back-to-back in a single-port pixel RAM and assembles one NCH-channel pixel per RAM offset. It sits between the frame RAM and the RLE encoder front end. It generalises the fixed 3-channel, free-running fetcher:

- channel count, data/address width, plane size and RAM read latency are parameters;
- start/done framing, frame restart, and a valid/ready output handshake replace the fixed hold counter.

## Interface
Parameters:
- NCH, 3, number of colour planes/channels (1..8)
- DW, 8, bits per channel sample
- AW, 16, RAM address width; NCH*PLANE must be <= 2^AW
- PLANE, 16384, pixels per plane and plane stride; channel c base = c*PLANE
- RD_LAT, 0, RAM read latency in cycles after address update (0 = async read, 1 = registered read)
- CONTINUOUS, 0, 1 = restart at offset 0 automatically after last pixel

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a frame; sampled only in IDLE
- a  out  AW  RAM address, registered
- spo  in  DW  RAM read data
- pix  out  NCH*DW  assembled pixel; channel 0 in bits [DW-1:0], channel c in [c*DW+DW-1:c*DW]
- valid  out  1  pix is valid
- ready  in  1  downstream accepts pix
- last  out  1  qualifies valid; high for offset PLANE-1
- busy  out  1  high from start acceptance until the frame ends
- done  out  1  one-cycle pulse after the last pixel's transfer

## Operation
- Reset state: every output is 0 (a, pix, valid, last, busy, done); state IDLE; offset=0, ch=0, wait counter=0.
- Internal registers:
  - offset, width clog2(PLANE);
  - ch, width clog2(NCH) (min 1);
  - latency counter, width 1 min.
- States:
  - IDLE: busy=0. On start=1, go to ADDR with offset=0, ch=0, busy=1.
  - ADDR: a <= ch*PLANE + offset, truncated to AW. Next state is WAIT if RD_LAT>0, else CAP.
  - WAIT: count RD_LAT-1 further cycles, then go to CAP.
  - CAP: pix[ch] <= spo.
    - If ch<NCH-1: ch++, go to ADDR.
    - Else: ch=0, valid<=1, last<=(offset==PLANE-1), go to OUT.
  - OUT: hold pix, valid, last and a stable until valid&&ready at an edge (transfer). On the transfer edge valid<=0 and last<=0, then:
    - Not last: offset++, go to ADDR.
    - Last, CONTINUOUS=0: done<=1, busy<=0, offset<=0, go to IDLE.
    - Last, CONTINUOUS=1: done<=1, offset<=0, go to ADDR; busy stays 1.
- done is a single-cycle pulse, cleared on the following edge.
- start asserted while busy=1 is ignored. A start in the same cycle as the done pulse (IDLE not yet entered) is ignored.
- ready is ignored outside OUT. valid never drops without a transfer.
- pix channels not yet recaptured for the current pixel keep the previous pixel's values. Only pix qualified by valid is meaningful.
- Offset wraps from PLANE-1 to 0 only via the last-transfer path; the offset register never overflows.
- Reset mid-frame aborts immediately: no done pulse, all outputs 0.

## Timing
- Per-channel fetch: 2+RD_LAT cycles (ADDR, RD_LAT waits, CAP). spo is sampled at the CAP edge, which is RD_LAT+1 edges after a was updated.
- First valid: start accepted at edge 0, valid high after edge NCH*(2+RD_LAT).
- Sustained period with ready=1: 1 + NCH*(2+RD_LAT) cycles per pixel. For NCH=3 and RD_LAT=0 that is 7 cycles.
- Frame length with ready=1: PLANE*(1+NCH*(2+RD_LAT)) cycles.
- done is high in the cycle after the final transfer edge.
- Backpressure: each cycle ready=0 in OUT adds exactly one cycle. No RAM accesses occur while stalled.

## Test plan
- Reset values: NCH=3, DW=8, AW=4, PLANE=4, RD_LAT=0. Assert rst asynchronously mid-cycle -> all outputs 0 immediately, with no clock edge needed.
- Basic frame: same parameters, RAM[i]=i*16+1, ready=1, start pulse.
  - a sequence per pixel k: k, 4+k, 8+k.
  - pix = {RAM[8+k],RAM[4+k],RAM[k]}, with valid every 7 cycles, 4 pixels total.
  - last only on k=3; done once, one cycle after the 4th transfer; busy=0 afterwards.
- Backpressure: hold ready=0 for 5 cycles on pixel 1 -> valid, pix, last and a held stable for the 5 cycles; pixel 1 transferred exactly once; frame 5 cycles longer.
- RD_LAT=1, NCH=4, PLANE=4, with a registered-read RAM model -> correct pix for all 4 pixels; first valid after edge 12; period 13 cycles.
- CONTINUOUS=1 -> after pixel 3 the next a is 0 without a start pulse; done pulses once per frame; busy stays 1; a start during the frame has no effect.
- Reset mid-frame during WAIT/OUT -> outputs 0 and no done pulse. A subsequent start yields a clean frame from offset 0.
